// File: rtl/prl_rx_msg_queue_if_if.sv
// Bundle of the PRL RX report bus between the RX state machine/parser, the
// report queue and the policy engine.
// The slave modport is the queue's view; the master modport is the
// environment's view (RX side and PE side together).
// Optional macro PRL_RX_MSG_QUEUE_DROP_CNT_EN adds the drop-counter signal.
interface prl_rx_msg_queue_if_if #(
  parameter int DEPTH  = 4,
  parameter int INFO_W = 66
`ifdef PRL_RX_MSG_QUEUE_DROP_CNT_EN
  ,
  parameter int DCNT_W = 8
`endif
);
  localparam int LW = $clog2(DEPTH + 1);

  logic              prl_rx_st_inform_pe_en;
  logic [2:0]        prl_rx_st_inform_pe_result;
  logic [1:0]        prl_rx_parser_message_type;
  logic [4:0]        prl_rx_parser_header_type;
  logic [2:0]        prl_rx_parser_sop_type;
  logic [INFO_W-1:0] prl_rx_info;
  logic              prl_rx_flush;
  logic              pl2pe_rx_en;
  logic              pe2pl_rx_ready;
  logic [6:0]        pl2pe_rx_type;
  logic [2:0]        pl2pe_rx_sop_type;
  logic [2:0]        pl2pe_rx_result;
  logic [INFO_W-1:0] pl2pe_rx_info;
  logic [LW-1:0]     pl2pe_rx_level;
  logic              pl2pe_rx_ovf;
  logic              pe2pl_rx_ovf_clr;
`ifdef PRL_RX_MSG_QUEUE_DROP_CNT_EN
  logic [DCNT_W-1:0] pl2pe_rx_drop_cnt;
`endif

  modport slave (
    input  prl_rx_st_inform_pe_en, prl_rx_st_inform_pe_result,
           prl_rx_parser_message_type, prl_rx_parser_header_type,
           prl_rx_parser_sop_type, prl_rx_info, prl_rx_flush,
           pe2pl_rx_ready, pe2pl_rx_ovf_clr,
`ifdef PRL_RX_MSG_QUEUE_DROP_CNT_EN
    output pl2pe_rx_drop_cnt,
`endif
    output pl2pe_rx_en, pl2pe_rx_type, pl2pe_rx_sop_type, pl2pe_rx_result,
           pl2pe_rx_info, pl2pe_rx_level, pl2pe_rx_ovf
  );

  modport master (
    output prl_rx_st_inform_pe_en, prl_rx_st_inform_pe_result,
           prl_rx_parser_message_type, prl_rx_parser_header_type,
           prl_rx_parser_sop_type, prl_rx_info, prl_rx_flush,
           pe2pl_rx_ready, pe2pl_rx_ovf_clr,
`ifdef PRL_RX_MSG_QUEUE_DROP_CNT_EN
    input  pl2pe_rx_drop_cnt,
`endif
    input  pl2pe_rx_en, pl2pe_rx_type, pl2pe_rx_sop_type, pl2pe_rx_result,
           pl2pe_rx_info, pl2pe_rx_level, pl2pe_rx_ovf
  );
endinterface

// File: rtl/prl_rx_msg_queue_if.sv
// PRL RX message report queue: DEPTH-entry show-ahead FIFO of received
// message reports presented to the policy engine via valid/ready.
// Optional macro PRL_RX_MSG_QUEUE_DROP_CNT_EN adds a saturating drop counter.
module prl_rx_msg_queue_if #(
  parameter int DEPTH  = 4,
  parameter int INFO_W = 66
`ifdef PRL_RX_MSG_QUEUE_DROP_CNT_EN
  ,
  parameter int DCNT_W = 8
`endif
) (
  input logic                   clk,
  input logic                   rst_n,
  prl_rx_msg_queue_if_if.slave  bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 13 + INFO_W;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] head_idx;
  logic [LW-1:0] level;
  logic          ovf;
  logic          full;
  logic          pop;
  logic          accept;
  logic          drop;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  // Flush overrides everything; a pop at full frees the slot for a same-cycle push.
  assign full       = (level == LW'(DEPTH));
  assign pop        = (level != '0) & bus.pe2pl_rx_ready & ~bus.prl_rx_flush;
  assign accept     = bus.prl_rx_st_inform_pe_en & ~bus.prl_rx_flush & (~full | pop);
  assign drop       = bus.prl_rx_st_inform_pe_en & ~bus.prl_rx_flush & full & ~pop;
  assign push_entry = {bus.prl_rx_parser_message_type, bus.prl_rx_parser_header_type,
                       bus.prl_rx_parser_sop_type, bus.prl_rx_st_inform_pe_result,
                       bus.prl_rx_info};

  // Storage is cleared on reset so the head outputs read as zero, never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (bus.prl_rx_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      if (accept && !pop)      level <= LW'(level + 1'b1);
      else if (!accept && pop) level <= LW'(level - 1'b1);
    end
  end

  // Sticky overflow; a drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf <= 1'b0;
    else if (drop)                 ovf <= 1'b1;
    else if (bus.pe2pl_rx_ovf_clr) ovf <= 1'b0;
  end

`ifdef PRL_RX_MSG_QUEUE_DROP_CNT_EN
  logic [DCNT_W-1:0] drop_cnt;

  // Saturating drop counter; a clear with a same-cycle drop leaves a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        drop_cnt <= '0;
    else if (bus.pe2pl_rx_ovf_clr)     drop_cnt <= drop ? DCNT_W'(1) : '0;
    else if (drop && (drop_cnt != '1)) drop_cnt <= DCNT_W'(drop_cnt + 1'b1);
  end

  assign bus.pl2pe_rx_drop_cnt = drop_cnt;
`endif

  // While empty, show the slot behind the read pointer so outputs stay put.
  always_comb begin
    head_idx = rd_ptr;
    if (level == '0) head_idx = (rd_ptr == '0) ? PW'(DEPTH - 1) : PW'(rd_ptr - 1'b1);
  end

  assign head                  = mem[head_idx];
  assign bus.pl2pe_rx_en       = (level != '0);
  assign bus.pl2pe_rx_type     = head[EW-1 -: 7];
  assign bus.pl2pe_rx_sop_type = head[EW-8 -: 3];
  assign bus.pl2pe_rx_result   = head[EW-11 -: 3];
  assign bus.pl2pe_rx_info     = head[INFO_W-1:0];
  assign bus.pl2pe_rx_level    = level;
  assign bus.pl2pe_rx_ovf      = ovf;
endmodule

// File: tb/tb_prl_rx_msg_queue_if.sv
// Bench for prl_rx_msg_queue_if: directed vectors, queue-based reference
// model and literal pins on key scenario results.
module tb_prl_rx_msg_queue_if;
  localparam int DEPTH  = 4;
  localparam int INFO_W = 66;
  localparam int EW     = 13 + INFO_W;
  localparam int DCMAX  = 255;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

`ifdef PRL_RX_MSG_QUEUE_DROP_CNT_EN
  prl_rx_msg_queue_if_if #(.DEPTH(DEPTH), .INFO_W(INFO_W), .DCNT_W(8)) bus_if ();
  prl_rx_msg_queue_if #(.DEPTH(DEPTH), .INFO_W(INFO_W), .DCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave));
`else
  prl_rx_msg_queue_if_if #(.DEPTH(DEPTH), .INFO_W(INFO_W)) bus_if ();
  prl_rx_msg_queue_if #(.DEPTH(DEPTH), .INFO_W(INFO_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave));
`endif

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] mdl_q [$];
  logic          mdl_ovf = 1'b0;
  int            mdl_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model; data only while a report is valid.
  task automatic checkOutput();
    check("en", 128'(bus_if.pl2pe_rx_en), 128'(mdl_q.size() != 0));
    check("level", 128'(bus_if.pl2pe_rx_level), 128'(mdl_q.size()));
    check("ovf", 128'(bus_if.pl2pe_rx_ovf), 128'(mdl_ovf));
`ifdef PRL_RX_MSG_QUEUE_DROP_CNT_EN
    check("drop_cnt", 128'(bus_if.pl2pe_rx_drop_cnt), 128'(mdl_cnt));
`endif
    if (mdl_q.size() != 0) begin
      check("type", 128'(bus_if.pl2pe_rx_type), 128'(mdl_q[0][EW-1 -: 7]));
      check("sop", 128'(bus_if.pl2pe_rx_sop_type), 128'(mdl_q[0][EW-8 -: 3]));
      check("result", 128'(bus_if.pl2pe_rx_result), 128'(mdl_q[0][EW-11 -: 3]));
      check("info", 128'(bus_if.pl2pe_rx_info), 128'(mdl_q[0][INFO_W-1:0]));
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare.
  task automatic applyStimulus(input logic push, input logic [6:0] typ, input logic [2:0] sop,
                               input logic [2:0] res, input logic [INFO_W-1:0] info,
                               input logic ready, input logic flush, input logic clr);
    logic pop;
    logic drop;
    bus_if.prl_rx_st_inform_pe_en     = push;
    bus_if.prl_rx_parser_message_type = typ[6:5];
    bus_if.prl_rx_parser_header_type  = typ[4:0];
    bus_if.prl_rx_parser_sop_type     = sop;
    bus_if.prl_rx_st_inform_pe_result = res;
    bus_if.prl_rx_info                = info;
    bus_if.pe2pl_rx_ready             = ready;
    bus_if.prl_rx_flush               = flush;
    bus_if.pe2pl_rx_ovf_clr           = clr;
    @(posedge clk);
    drop = 1'b0;
    if (flush) begin
      mdl_q.delete();
    end else begin
      pop  = (mdl_q.size() != 0) && ready;
      drop = push && (mdl_q.size() == DEPTH) && !pop;
      if (pop) void'(mdl_q.pop_front());
      if (push && !drop) mdl_q.push_back({typ, sop, res, info});
    end
    if (drop)     mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
    if (clr)                         mdl_cnt = drop ? 1 : 0;
    else if (drop && mdl_cnt < DCMAX) mdl_cnt++;
    #1;
    checkOutput();
  endtask

  task automatic pushMsg(input logic [6:0] typ, input logic [INFO_W-1:0] info, input logic ready);
    applyStimulus(1'b1, typ, typ[2:0], ~typ[2:0], info, ready, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ready);
    applyStimulus(1'b0, 7'h0, 3'h0, 3'h0, '0, ready, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_en"}, 128'(bus_if.pl2pe_rx_en), 128'(0));
    check({tag, "_level"}, 128'(bus_if.pl2pe_rx_level), 128'(0));
    check({tag, "_ovf"}, 128'(bus_if.pl2pe_rx_ovf), 128'(0));
    check({tag, "_type"}, 128'(bus_if.pl2pe_rx_type), 128'(0));
    check({tag, "_sop"}, 128'(bus_if.pl2pe_rx_sop_type), 128'(0));
    check({tag, "_result"}, 128'(bus_if.pl2pe_rx_result), 128'(0));
    check({tag, "_info"}, 128'(bus_if.pl2pe_rx_info), 128'(0));
`ifdef PRL_RX_MSG_QUEUE_DROP_CNT_EN
    check({tag, "_drop_cnt"}, 128'(bus_if.pl2pe_rx_drop_cnt), 128'(0));
`endif
  endtask

  task automatic singlePush(input string tag);
    applyStimulus(1'b1, 7'h01, 3'd0, 3'b001, 66'h1234, 1'b1, 1'b0, 1'b0);
    check({tag, "_en"}, 128'(bus_if.pl2pe_rx_en), 128'(1));
    check({tag, "_type"}, 128'(bus_if.pl2pe_rx_type), 128'(7'h01));
    check({tag, "_result"}, 128'(bus_if.pl2pe_rx_result), 128'(3'b001));
    check({tag, "_info"}, 128'(bus_if.pl2pe_rx_info), 128'(66'h1234));
    idle(1'b1);
    check({tag, "_en_gone"}, 128'(bus_if.pl2pe_rx_en), 128'(0));
    check({tag, "_level0"}, 128'(bus_if.pl2pe_rx_level), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.prl_rx_st_inform_pe_en     = 1'b0;
    bus_if.prl_rx_parser_message_type = '0;
    bus_if.prl_rx_parser_header_type  = '0;
    bus_if.prl_rx_parser_sop_type     = '0;
    bus_if.prl_rx_st_inform_pe_result = '0;
    bus_if.prl_rx_info                = '0;
    bus_if.pe2pl_rx_ready             = 1'b0;
    bus_if.prl_rx_flush               = 1'b0;
    bus_if.pe2pl_rx_ovf_clr           = 1'b0;
    #12;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single report, PE always ready.
    idle(1'b1);
    singlePush("s1");

    // Four back-to-back reports with PE stalled, then drained in order.
    for (int i = 0; i < 4; i++) pushMsg(7'(8'h10 + i), 66'(32'hA0 + i), 1'b0);
    check("s2_level4", 128'(bus_if.pl2pe_rx_level), 128'(4));
    check("s2_head", 128'(bus_if.pl2pe_rx_type), 128'(7'h10));
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Overflow, clear, and drop colliding with clear.
    for (int i = 0; i < 4; i++) pushMsg(7'(8'h20 + i), 66'(64'hDEAD_0000 + i), 1'b0);
    pushMsg(7'h3F, 66'h3_FFFF_FFFF_FFFF_FFFF, 1'b0);
    check("s3_ovf", 128'(bus_if.pl2pe_rx_ovf), 128'(1));
    check("s3_level", 128'(bus_if.pl2pe_rx_level), 128'(4));
    check("s3_head", 128'(bus_if.pl2pe_rx_type), 128'(7'h20));
    applyStimulus(1'b0, 7'h0, 3'h0, 3'h0, '0, 1'b0, 1'b0, 1'b1);
    check("s3_ovf_clr", 128'(bus_if.pl2pe_rx_ovf), 128'(0));
    applyStimulus(1'b1, 7'h3E, 3'h1, 3'h2, 66'h77, 1'b0, 1'b0, 1'b1);
    check("s3_set_wins", 128'(bus_if.pl2pe_rx_ovf), 128'(1));
    applyStimulus(1'b0, 7'h0, 3'h0, 3'h0, '0, 1'b0, 1'b0, 1'b1);

    // Full queue: push with pop in the same cycle, new entry reaches head after 3 pops.
    applyStimulus(1'b1, 7'h55, 3'h5, 3'h6, 66'h5555, 1'b1, 1'b0, 1'b0);
    check("s4_level", 128'(bus_if.pl2pe_rx_level), 128'(4));
    check("s4_no_ovf", 128'(bus_if.pl2pe_rx_ovf), 128'(0));
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("s4_tail", 128'(bus_if.pl2pe_rx_type), 128'(7'h55));
    check("s4_tail_info", 128'(bus_if.pl2pe_rx_info), 128'(66'h5555));
    idle(1'b1);

    // Flush with a simultaneous push at level 3.
    for (int i = 0; i < 3; i++) pushMsg(7'(8'h40 + i), 66'(i), 1'b0);
    applyStimulus(1'b1, 7'h4F, 3'h3, 3'h3, 66'hF, 1'b1, 1'b1, 1'b0);
    check("s5_level", 128'(bus_if.pl2pe_rx_level), 128'(0));
    check("s5_en", 128'(bus_if.pl2pe_rx_en), 128'(0));
    check("s5_ovf", 128'(bus_if.pl2pe_rx_ovf), 128'(0));
    pushMsg(7'h4A, 66'hABC, 1'b0);
    check("s5_after", 128'(bus_if.pl2pe_rx_type), 128'(7'h4A));
    idle(1'b1);

    // Asynchronous reset mid-stream with level 2 and ovf set.
    for (int i = 0; i < 5; i++) pushMsg(7'(8'h60 + i), 66'(i + 1), 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("s6_level2", 128'(bus_if.pl2pe_rx_level), 128'(2));
    check("s6_ovf", 128'(bus_if.pl2pe_rx_ovf), 128'(1));
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("s6_rst");
    mdl_q.delete();
    mdl_ovf = 1'b0;
    mdl_cnt = 0;
    bus_if.prl_rx_st_inform_pe_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput();
    singlePush("s6_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prl_rx_msg_queue_if.md
Name: prl_rx_msg_queue_if

Overview:
Parametrised successor to the PRL RX message interface. Queues each received-message report from the PRL RX state machine, tagged with parsed header fields and a generic info payload, in a DEPTH-entry FIFO. Presents the reports to the policy engine through a valid/ready handshake, so back-to-back messages are not lost while the PE is busy. Sits between the PRL RX state machine/parser and the PE.

Parameters:
DEPTH, 4, number of queued reports; legal range 2..16, any integer (non-power-of-two allowed).
INFO_W, 66, width of the info payload per report.
LW, $clog2(DEPTH+1), width of the level output; derived, never overridden.
DCNT_W, 8, drop-counter width (used only with the optional feature).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
prl_rx_st_inform_pe_en  in  1  one-cycle push strobe from RX state machine
prl_rx_st_inform_pe_result  in  3  message result code
prl_rx_parser_message_type  in  2  message class (ctrl/data/ext)
prl_rx_parser_header_type  in  5  header message type
prl_rx_parser_sop_type  in  3  SOP type
prl_rx_info  in  INFO_W  packed payload fields from parser
prl_rx_flush  in  1  discard all queued reports (hard reset / detach)
pl2pe_rx_en  out  1  head report valid
pe2pl_rx_ready  in  1  PE accepts head report
pl2pe_rx_type  out  7  {message_type, header_type} of head
pl2pe_rx_sop_type  out  3  head SOP type
pl2pe_rx_result  out  3  head result
pl2pe_rx_info  out  INFO_W  head payload
pl2pe_rx_level  out  LW  entries currently queued
pl2pe_rx_ovf  out  1  sticky overflow flag
pe2pl_rx_ovf_clr  in  1  clears pl2pe_rx_ovf
pl2pe_rx_drop_cnt  out  DCNT_W  dropped-report count (only with PRL_RX_MSG_QUEUE_DROP_CNT_EN)

Behaviour:
- Reset: all outputs 0; read/write pointers 0; level 0; ovf 0; storage contents don't-care.
- Entry = {type[6:0], sop[2:0], result[2:0], info}; captured on push cycle.
- Show-ahead FIFO: outputs reflect the head entry directly from registered storage; pl2pe_rx_en = (level != 0).
- Latency: push at cycle N into empty queue -> pl2pe_rx_en=1 with that entry at N+1.
- Pop = pl2pe_rx_en & pe2pl_rx_ready; next entry is visible the following cycle. ready while en=0 has no effect.
- Data outputs hold stable while en=1 and ready=0. Outputs are don't-care-but-stable while en=0, retaining the last popped entry (no X).
- Pointers wrap from DEPTH-1 to 0.
- Push when level<DEPTH: accepted, level+1.
- Push and pop in the same cycle: both performed, level unchanged. This holds also at level==DEPTH, where the pop frees the slot and the push is accepted with no overflow.
- Push when level==DEPTH without a pop: report dropped (oldest kept), pl2pe_rx_ovf set.
- Flush: highest priority. Pointers and level go to 0 next cycle; a same-cycle push or pop is ignored and the push is not counted as a drop. ovf is unaffected by flush.
- ovf: set on a drop, cleared by pe2pl_rx_ovf_clr; set wins if both occur in the same cycle.
- No internal state machine beyond the FIFO; control is the pointer/level logic above.

Optional Feature:
Macro PRL_RX_MSG_QUEUE_DROP_CNT_EN.
- Defined: pl2pe_rx_drop_cnt exists. It increments on every dropped push, saturates at all-ones, and clears on pe2pl_rx_ovf_clr. If a clear and a drop occur in the same cycle, the count becomes 1. Reset value 0.
- Not defined: port and counter are absent. The overflow flag alone reports drops.

Test Plan:
- Single push, type=0x01 (GoodCRC-class), sop=0, result=3'b001, info=66'h1234, ready held 1 -> en=1 for exactly 1 cycle at N+1 with those values; level returns to 0.
- Four pushes on consecutive cycles, ready=0 (DEPTH=4) -> level=4, en=1, head = first push; then ready=1 -> pops in push order over 4 cycles, level 3,2,1,0.
- Fill to 4, fifth push with ready=0 -> fifth dropped, ovf=1, drop_cnt=1, queue contents unchanged; ovf_clr pulse -> ovf=0, drop_cnt=0.
- Full queue, push and pop in the same cycle -> no drop, level stays 4, new entry appears at the tail after 3 further pops.
- Level 3, flush asserted together with a push -> next cycle level=0, en=0, no drop counted; next push appears at N+1.
- Assert rst_n low mid-stream with level 2 and ovf=1 -> all outputs 0 immediately (asynchronous reset); after release, a push behaves as in scenario 1.
